// File: rtl/dmem_if.sv
// Load/store request and response channel between the rv32i core
// and its data memory.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_func3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_func3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, programmable wait states,
// byte/halfword/word stores and sign/zero-extended loads with error reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD  = 4'(LATENCY - 1);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_cnt;

    logic        write_q;
    logic [2:0]  func3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        error_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        wait_done;
    logic        resp_done;
    logic        commit;

    logic [1:0]    lane;
    logic [1:0]    size;
    logic [AW-1:0] word_idx;
    logic          out_of_range;
    logic          misaligned;
    logic          bad_func3;
    logic          access_error;
    logic [3:0]    byte_en;
    logic [31:0]   store_data;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shifted;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_value;

    assign accept    = bus.req_valid && (state == IDLE);
    assign wait_done = (state == WAIT) && (wait_cnt == 4'd0);
    assign resp_done = (state == RESP) && bus.resp_ready;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = WAIT;
            WAIT:    if (wait_done) next_state = RESP;
            RESP:    if (resp_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Wait-state down-counter: loaded on acceptance, WAIT lasts LATENCY cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            func3_q <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            write_q <= bus.req_write;
            func3_q <= bus.req_func3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    assign lane     = addr_q[1:0];
    assign size     = func3_q[1:0];
    assign word_idx = addr_q[AW+1:2];

    // Loads allow 000,001,010,100,101; stores allow only 000,001,010.
    always_comb begin
        out_of_range = ({1'b0, addr_q} >= ADDR_LIMIT);
        misaligned   = ((size == 2'b01) && lane[0]) ||
                       ((size == 2'b10) && (lane != 2'b00));
        if (write_q) begin
            bad_func3 = func3_q[2] || (size == 2'b11);
        end else begin
            bad_func3 = (size == 2'b11) || (func3_q[2] && (size == 2'b10));
        end
        access_error = out_of_range || misaligned || bad_func3;
    end

    always_comb begin
        byte_en    = 4'b0000;
        store_data = wdata_q;
        case (size)
            2'b00: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                byte_en    = 4'b1111;
                store_data = wdata_q;
            end
            default: begin
                byte_en    = 4'b0000;
                store_data = wdata_q;
            end
        endcase
    end

    assign commit = wait_done && write_q && !access_error;

    // Memory has no reset; a store lands on the WAIT-to-RESP edge only.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_word    = mem[word_idx];
    assign rd_shifted = rd_word >> {lane, 3'b000};
    assign rd_byte    = rd_shifted[7:0];
    assign rd_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_value = 32'd0;
        case (func3_q)
            3'b000:  load_value = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_value = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_value = rd_word;
            3'b100:  load_value = {24'd0, rd_byte};
            3'b101:  load_value = {16'd0, rd_half};
            default: load_value = 32'd0;
        endcase
    end

    // Response registers hold steady through backpressure and clear on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else if (wait_done) begin
            rdata_q <= (!write_q && !access_error) ? load_value : 32'd0;
            error_q <= access_error;
        end else if (resp_done) begin
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder with one LATENCY=1 and one LATENCY=4 instance.
module tb_dmem_responder;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    dmem_if bus1 ();
    dmem_if bus4 ();

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One complete access on the LATENCY=1 instance; request fields are
    // scrambled right after acceptance so only the registered copy matters.
    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic err, output int cycles);
        bit got;
        rdata  = 32'd0;
        err    = 1'b0;
        cycles = 0;
        got    = 0;
        bus1.req_valid  = 1'b1;
        bus1.req_write  = wr;
        bus1.req_func3  = f3;
        bus1.req_addr   = addr;
        bus1.req_wdata  = wdata;
        bus1.resp_ready = 1'b1;
        for (int i = 0; i < 20 && !bus1.req_ready; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        bus1.req_write = ~wr;
        bus1.req_func3 = 3'b111;
        bus1.req_addr  = ~addr;
        bus1.req_wdata = ~wdata;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus1.resp_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checkOutput("resp_timeout", 32'd0, 32'd1);
        end else begin
            rdata = bus1.resp_rdata;
            err   = bus1.resp_error;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        int          a1;
        int          a2;
        bit          fire;
        bit          got;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_func3 = 3'd0;
        bus1.req_addr  = 32'd0; bus1.req_wdata = 32'd0; bus1.resp_ready = 1'b1;
        bus4.req_valid = 1'b0; bus4.req_write = 1'b0; bus4.req_func3 = 3'd0;
        bus4.req_addr  = 32'd0; bus4.req_wdata = 32'd0; bus4.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset state");
        checkOutput("rst_req_ready",  32'(bus1.req_ready),  32'd1);
        checkOutput("rst_resp_valid", 32'(bus1.resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", bus1.resp_rdata,      32'd0);
        checkOutput("rst_resp_error", 32'(bus1.resp_error), 32'd0);

        $display("[TB] word store and load");
        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, cyc);
        checkOutput("sw_latency", 32'(cyc), 32'd1);
        checkOutput("sw_error",   32'(er),  32'd0);
        checkOutput("sw_rdata",   rd,       32'd0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd, er, cyc);
        checkOutput("lw_10", rd, 32'hDEADBEEF);
        checkOutput("lw_10_error", 32'(er), 32'd0);

        $display("[TB] byte and halfword lanes");
        applyStimulus(1'b1, 3'b000, 32'h11, 32'hAAAAAA80, rd, er, cyc);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd, er, cyc);
        checkOutput("lw_after_sb", rd, 32'hDEAD80EF);
        applyStimulus(1'b0, 3'b000, 32'h11, 32'h0, rd, er, cyc);
        checkOutput("lb_11", rd, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h11, 32'h0, rd, er, cyc);
        checkOutput("lbu_11", rd, 32'h00000080);
        applyStimulus(1'b1, 3'b001, 32'h12, 32'h55551234, rd, er, cyc);
        applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, rd, er, cyc);
        checkOutput("lh_12", rd, 32'h00001234);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd, er, cyc);
        checkOutput("lw_after_sh", rd, 32'h123480EF);
        applyStimulus(1'b0, 3'b101, 32'h10, 32'h0, rd, er, cyc);
        checkOutput("lhu_10", rd, 32'h000080EF);
        applyStimulus(1'b0, 3'b001, 32'h10, 32'h0, rd, er, cyc);
        checkOutput("lh_10", rd, 32'hFFFF80EF);

        $display("[TB] error cases");
        applyStimulus(1'b0, 3'b010, 32'h13, 32'h0, rd, er, cyc);
        checkOutput("err_lw_13", 32'(er), 32'd1);
        checkOutput("err_lw_13_rdata", rd, 32'd0);
        applyStimulus(1'b1, 3'b001, 32'h11, 32'h0000FFFF, rd, er, cyc);
        checkOutput("err_sh_11", 32'(er), 32'd1);
        checkOutput("err_sh_11_rdata", rd, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h400, 32'h0, rd, er, cyc);
        checkOutput("err_lw_range", 32'(er), 32'd1);
        checkOutput("err_lw_range_rdata", rd, 32'd0);
        applyStimulus(1'b0, 3'b111, 32'h10, 32'h0, rd, er, cyc);
        checkOutput("err_func3_111", 32'(er), 32'd1);
        checkOutput("err_func3_111_rdata", rd, 32'd0);
        applyStimulus(1'b1, 3'b100, 32'h10, 32'h00000000, rd, er, cyc);
        checkOutput("err_store_func3", 32'(er), 32'd1);
        applyStimulus(1'b1, 3'b010, 32'h410, 32'h00000000, rd, er, cyc);
        checkOutput("err_sw_range", 32'(er), 32'd1);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd, er, cyc);
        checkOutput("lw_after_errors", rd, 32'h123480EF);

        $display("[TB] backpressure");
        bus1.req_valid  = 1'b1;
        bus1.req_write  = 1'b0;
        bus1.req_func3  = 3'b010;
        bus1.req_addr   = 32'h10;
        bus1.req_wdata  = 32'h0;
        bus1.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_resp_valid", 32'(bus1.resp_valid), 32'd1);
            checkOutput("bp_resp_rdata", bus1.resp_rdata,      32'h123480EF);
            checkOutput("bp_resp_error", 32'(bus1.resp_error), 32'd0);
            checkOutput("bp_req_ready",  32'(bus1.req_ready),  32'd0);
            if (k == 1) begin
                bus1.req_valid = 1'b1;
                bus1.req_write = 1'b1;
                bus1.req_func3 = 3'b010;
                bus1.req_addr  = 32'h10;
                bus1.req_wdata = 32'h0;
            end else if (k == 2) begin
                bus1.req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus1.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_done_resp_valid", 32'(bus1.resp_valid), 32'd0);
        checkOutput("bp_done_req_ready",  32'(bus1.req_ready),  32'd1);
        checkOutput("bp_done_rdata",      bus1.resp_rdata,      32'd0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd, er, cyc);
        checkOutput("lw_after_bp", rd, 32'h123480EF);

        $display("[TB] LATENCY=4 back-to-back");
        a1  = -1;
        a2  = -1;
        got = 0;
        bus4.req_valid = 1'b1;
        bus4.req_write = 1'b1;
        bus4.req_func3 = 3'b010;
        bus4.req_addr  = 32'h40;
        bus4.req_wdata = 32'hCAFEF00D;
        for (int n = 0; n < 40 && a2 < 0; n++) begin
            @(negedge clk);
            fire = bus4.req_valid && bus4.req_ready;
            @(posedge clk);
            #1;
            if (fire && a1 < 0) begin
                a1 = n;
                bus4.req_write = 1'b0;
                bus4.req_wdata = 32'h0;
            end else if (fire) begin
                a2 = n;
                bus4.req_valid = 1'b0;
            end
        end
        checkOutput("l4_accept_gap", 32'(a2 - a1), 32'd6);
        for (int n = 0; n < 40; n++) begin
            if (bus4.resp_valid) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("l4_resp_seen", 32'(got), 32'd1);
        checkOutput("l4_lw_rdata",  bus4.resp_rdata,      32'hCAFEF00D);
        checkOutput("l4_lw_error",  32'(bus4.resp_error), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] reset during store wait");
        applyStimulus(1'b1, 3'b010, 32'h20, 32'h00000011, rd, er, cyc);
        bus1.req_valid  = 1'b1;
        bus1.req_write  = 1'b1;
        bus1.req_func3  = 3'b010;
        bus1.req_addr   = 32'h20;
        bus1.req_wdata  = 32'h00000055;
        bus1.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        checkOutput("mid_req_ready_wait", 32'(bus1.req_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_req_ready",  32'(bus1.req_ready),  32'd1);
        checkOutput("arst_resp_valid", 32'(bus1.resp_valid), 32'd0);
        checkOutput("arst_resp_rdata", bus1.resp_rdata,      32'd0);
        checkOutput("arst_resp_error", 32'(bus1.resp_error), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, rd, er, cyc);
        checkOutput("lw_20_after_reset", rd, 32'h00000011);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd, er, cyc);
        checkOutput("lw_10_after_reset", rd, 32'h123480EF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
